// File: rtl/l2_request_scheduler.sv
// Shared L2 port arbiter: I-cache, D-cache and prefetcher, one latched transaction at a time.
// Define L2_SCHED_AGING_EN to let a waiting I-cache request overtake D after AGE_LIMIT grants.
module l2_request_scheduler #(
  parameter int AGE_LIMIT = 4,
  parameter int ADDR_W    = 16,
  parameter int BLOCK_W   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               icache_pmem_read,
  input  logic [ADDR_W-1:0]  icache_pmem_address,
  output logic               icache_pmem_resp,
  input  logic               dcache_pmem_read,
  input  logic               dcache_pmem_write,
  input  logic [ADDR_W-1:0]  dcache_pmem_address,
  input  logic [BLOCK_W-1:0] dcache_pmem_wdata,
  output logic               dcache_pmem_resp,
  input  logic               pf_req,
  input  logic [ADDR_W-1:0]  pf_address,
  output logic               pf_resp,
  output logic [ADDR_W-1:0]  l2_address,
  output logic [BLOCK_W-1:0] l2_wdata,
  output logic               l2_read,
  output logic               l2_write,
  input  logic               l2_resp,
  output logic               ld_regs,
  output logic [1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_I    = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;
  localparam logic [1:0] G_PF   = 2'd3;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] winner;
  logic       d_req;
  logic       i_req;
  logic       age_hit;
  logic       d_go;
  logic       i_go;
  logic       p_go;
  logic       busy;

  assign d_req = dcache_pmem_read | dcache_pmem_write;
  assign i_req = icache_pmem_read;

`ifdef L2_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age;
  logic             d_over_i;

  assign age_hit  = (age == AGE_MAX);
  assign d_over_i = (winner == G_D) & i_req;

  // Counts D grants that passed over a waiting I; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      age <= '0;
    end else if (state == IDLE && winner != G_NONE) begin
      if (!d_over_i)
        age <= '0;
      else if (age != AGE_MAX)
        age <= age + 1'b1;
    end
  end
`else
  assign age_hit = (AGE_LIMIT < 0);
`endif

  assign d_go = d_req & ~(i_req & age_hit);
  assign i_go = i_req & ~d_go;
  assign p_go = pf_req & ~d_req & ~i_req;

  always_comb begin
    winner = G_NONE;
    unique case (1'b1)
      d_go:    winner = G_D;
      i_go:    winner = G_I;
      p_go:    winner = G_PF;
      default: winner = G_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= G_NONE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (winner != G_NONE) begin
            owner <= winner;
            state <= BUSY;
          end
          case (winner)
            G_D: begin
              l2_address <= dcache_pmem_address;
              l2_wdata   <= dcache_pmem_wdata;
              l2_write   <= dcache_pmem_write;
              l2_read    <= ~dcache_pmem_write;
            end
            G_I: begin
              l2_address <= icache_pmem_address;
              l2_wdata   <= '0;
              l2_write   <= 1'b0;
              l2_read    <= 1'b1;
            end
            G_PF: begin
              l2_address <= pf_address;
              l2_wdata   <= '0;
              l2_write   <= 1'b0;
              l2_read    <= 1'b1;
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (l2_resp) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          owner <= G_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_id = owner;
  assign busy     = (state == BUSY);

  assign icache_pmem_resp = busy & l2_resp & (owner == G_I);
  assign dcache_pmem_resp = busy & l2_resp & (owner == G_D);
  assign pf_resp          = busy & l2_resp & (owner == G_PF);

  // Prefetch traffic alone never stalls the pipeline.
  always_comb begin
    ld_regs = 1'b0;
    unique case (state)
      IDLE:  ld_regs = ~(i_req | d_req);
      BUSY:  ld_regs = (owner == G_PF) & ~(i_req | d_req);
      DRAIN: begin
        case (owner)
          G_I:     ld_regs = ~d_req;
          G_D:     ld_regs = ~i_req;
          default: ld_regs = ~(i_req | d_req);
        endcase
      end
      default: ld_regs = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Bench for l2_request_scheduler: directed scenarios then random rounds
// against a transaction-level priority/aging model.
module tb_l2_request_scheduler;

  localparam int AGE_LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         icache_pmem_read = 1'b0;
  logic [15:0]  icache_pmem_address = '0;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read = 1'b0;
  logic         dcache_pmem_write = 1'b0;
  logic [15:0]  dcache_pmem_address = '0;
  logic [127:0] dcache_pmem_wdata = '0;
  logic         dcache_pmem_resp;
  logic         pf_req = 1'b0;
  logic [15:0]  pf_address = '0;
  logic         pf_resp;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic         l2_resp = 1'b0;
  logic         ld_regs;
  logic [1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  // Requester-side model state
  bit i_pend = 1'b0;
  bit pf_pend = 1'b0;
  bit d_wr = 1'b0;
  int d_left = 0;
`ifdef L2_SCHED_AGING_EN
  int age_m = 0;
`endif

  l2_request_scheduler #(
    .AGE_LIMIT(AGE_LIMIT),
    .ADDR_W(16),
    .BLOCK_W(128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .icache_pmem_read(icache_pmem_read),
    .icache_pmem_address(icache_pmem_address),
    .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read),
    .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address),
    .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_resp(dcache_pmem_resp),
    .pf_req(pf_req),
    .pf_address(pf_address),
    .pf_resp(pf_resp),
    .l2_address(l2_address),
    .l2_wdata(l2_wdata),
    .l2_read(l2_read),
    .l2_write(l2_write),
    .l2_resp(l2_resp),
    .ld_regs(ld_regs),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // op: 0 read, 1 write, 2 read+write (a write)
  task automatic raise_d(input logic [15:0] a,
                         input logic [127:0] wd,
                         input int op);
    dcache_pmem_address = a;
    dcache_pmem_wdata   = wd;
    dcache_pmem_read    = (op != 1);
    dcache_pmem_write   = (op != 0);
    d_wr                = (op != 0);
  endtask

  task automatic raise_rand_d();
    raise_d(16'($urandom),
            {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(0, 2)));
  endtask

  // Next grant: 1 = I, 2 = D, 3 = prefetch
  function automatic int pick();
    bit aged;
`ifdef L2_SCHED_AGING_EN
    aged = (age_m == AGE_LIMIT);
`else
    aged = 1'b0;
`endif
    if (d_left > 0 && !(i_pend && aged)) return 2;
    if (i_pend) return 1;
    if (pf_pend) return 3;
    return 0;
  endfunction

  task automatic upd_age(input int w);
`ifdef L2_SCHED_AGING_EN
    if (w == 2 && i_pend)
      age_m = (age_m < AGE_LIMIT) ? age_m + 1 : age_m;
    else
      age_m = 0;
`else
    if (w < 0) $display("unexpected winner");
`endif
  endtask

  // Called at a negedge in IDLE with requests driven.
  task automatic serve_one(input int lat,
                           input bit late_i,
                           output int g);
    int n;
    int w;
    logic [15:0] ea;
    bit ew;
    logic [2:0] er;
    bit eld;
    w = pick();
    g = 0;
    ea = '0;
    ew = 1'b0;
    er = 3'b000;
    if (w == 1) begin
      ea = icache_pmem_address;
      er = 3'b100;
    end else if (w == 2) begin
      ea = dcache_pmem_address;
      ew = d_wr;
      er = 3'b010;
    end else begin
      ea = pf_address;
      er = 3'b001;
    end
    upd_age(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_read || l2_write) && n < 20);
    g = int'(grant_id);
    chk("grant_latency", 128'(n), 128'(1));
    chk("grant_id", 128'(grant_id), 128'(w));
    chk("l2_address", 128'(l2_address), 128'(ea));
    chk("l2_write", 128'(l2_write), 128'(ew));
    chk("l2_read", 128'(l2_read), 128'(!ew));
    if (ew) chk("l2_wdata", l2_wdata, dcache_pmem_wdata);
    eld = (w == 3) && !i_pend && d_left == 0;
    chk("ld_regs_busy", 128'(ld_regs), 128'(eld));
    for (int k = 1; k < lat; k++) begin
      if (late_i && k == 2) begin
        chk("ld_regs_pf", 128'(ld_regs), 128'(1));
        icache_pmem_read = 1'b1;
        i_pend = 1'b1;
        #1;
        chk("ld_regs_late_i", 128'(ld_regs), 128'(0));
      end
      @(negedge clk);
      chk("addr_hold", 128'(l2_address), 128'(ea));
      chk("strobe_hold", 128'({l2_read, l2_write}),
          128'({!ew, ew}));
    end
    l2_resp = 1'b1;
    #1;
    chk("resp", 128'({icache_pmem_resp, dcache_pmem_resp, pf_resp}),
        128'(er));
    @(negedge clk);
    l2_resp = 1'b0;
    if (w == 1) begin
      icache_pmem_read = 1'b0;
      i_pend = 1'b0;
    end else if (w == 2) begin
      dcache_pmem_read = 1'b0;
      dcache_pmem_write = 1'b0;
      d_left--;
    end else begin
      pf_req = 1'b0;
      pf_pend = 1'b0;
    end
    #1;
    chk("drain_strobe", 128'({l2_read, l2_write}), 128'(0));
    chk("drain_resp", 128'({icache_pmem_resp, dcache_pmem_resp, pf_resp}),
        128'(0));
    if (w == 1) eld = (d_left == 0);
    else if (w == 2) eld = !i_pend;
    else eld = !(i_pend || d_left > 0);
    chk("ld_regs_drain", 128'(ld_regs), 128'(eld));
    @(negedge clk);
    if (w == 2 && d_left > 0) raise_rand_d();
    #1;
    chk("idle_grant", 128'(grant_id), 128'(0));
    chk("ld_regs_idle", 128'(ld_regs), 128'(!(i_pend || d_left > 0)));
  endtask

  initial begin
    int g;
    int idx;
    int iwin;
    int exp_win;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 128'(grant_id), 128'(0));
    chk("rst_read", 128'(l2_read), 128'(0));
    chk("rst_write", 128'(l2_write), 128'(0));
    chk("rst_addr", 128'(l2_address), 128'(0));
    chk("rst_wdata", l2_wdata, 128'(0));
    chk("rst_ld", 128'(ld_regs), 128'(1));
    chk("rst_resp", 128'({icache_pmem_resp, dcache_pmem_resp, pf_resp}),
        128'(0));
    reset = 1'b0;
    @(negedge clk);

    // I read alone, 5-cycle L2
    icache_pmem_address = 16'h1230;
    icache_pmem_read = 1'b1;
    i_pend = 1'b1;
    serve_one(5, 1'b0, g);
    chk("t1_grant", 128'(g), 128'(1));

    // I and D together: D first, I immediately after
    icache_pmem_address = 16'h0100;
    icache_pmem_read = 1'b1;
    i_pend = 1'b1;
    raise_d(16'h2200, 128'h0, 0);
    d_left = 1;
    serve_one(3, 1'b0, g);
    chk("t2_first", 128'(g), 128'(2));
    serve_one(2, 1'b0, g);
    chk("t2_second", 128'(g), 128'(1));

    // D read+write: write wins
    raise_d(16'h3000, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 2);
    d_left = 1;
    serve_one(2, 1'b0, g);
    chk("t3_grant", 128'(g), 128'(2));

    // Aging: D keeps re-requesting while I waits
    raise_rand_d();
    d_left = 6;
    icache_pmem_address = 16'h0AA0;
    icache_pmem_read = 1'b1;
    i_pend = 1'b1;
    idx = 0;
    iwin = 0;
    while ((i_pend || d_left > 0) && idx < 20) begin
      serve_one(2, 1'b0, g);
      idx++;
      if (g == 1 && iwin == 0) iwin = idx;
    end
`ifdef L2_SCHED_AGING_EN
    exp_win = 5;
`else
    exp_win = 7;
`endif
    chk("age_i_win", 128'(iwin), 128'(exp_win));

    // Prefetch runs to completion, I arrives mid-BUSY
    pf_address = 16'h4040;
    pf_req = 1'b1;
    pf_pend = 1'b1;
    serve_one(5, 1'b1, g);
    chk("t5_pf", 128'(g), 128'(3));
    serve_one(2, 1'b0, g);
    chk("t5_i", 128'(g), 128'(1));

    // Reset in 2nd BUSY cycle of a D read
    raise_d(16'h5000, 128'h0, 0);
    d_left = 1;
    @(negedge clk);
    chk("t6_busy", 128'(l2_read), 128'(1));
    @(negedge clk);
    reset = 1'b1;
    dcache_pmem_read = 1'b0;
    d_left = 0;
    @(negedge clk);
    chk("t6_strobes", 128'({l2_read, l2_write}), 128'(0));
    chk("t6_grant", 128'(grant_id), 128'(0));
    chk("t6_ld", 128'(ld_regs), 128'(1));
    reset = 1'b0;
`ifdef L2_SCHED_AGING_EN
    age_m = 0;
`endif
    icache_pmem_address = 16'h6000;
    icache_pmem_read = 1'b1;
    i_pend = 1'b1;
    serve_one(3, 1'b0, g);
    chk("t6_after", 128'(g), 128'(1));

    // Random rounds against the model
    for (int r = 0; r < 25; r++) begin
      int dn;
      bit ion;
      bit pon;
      int it;
      dn = int'($urandom_range(0, 3));
      ion = 1'($urandom_range(0, 1));
      pon = 1'($urandom_range(0, 1));
      if (dn == 0 && !ion) pon = 1'b1;
      if (ion) begin
        icache_pmem_address = 16'($urandom);
        icache_pmem_read = 1'b1;
        i_pend = 1'b1;
      end
      if (pon) begin
        pf_address = 16'($urandom);
        pf_req = 1'b1;
        pf_pend = 1'b1;
      end
      if (dn > 0) begin
        d_left = dn;
        raise_rand_d();
      end
      it = 0;
      while ((i_pend || pf_pend || d_left > 0) && it < 20) begin
        serve_one(int'($urandom_range(1, 5)), 1'b0, g);
        it++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
